// File: rtl/mms_pkg.sv
// Shared MMU types and sizes: ITLB geometry, refill FSM state encoding,
// and a small saturating-increment helper for event counters.
`ifndef TLB_ENTRY_SIZE
`define TLB_ENTRY_SIZE 32
`endif

package mms_pkg;

    localparam int TLB_ENTRY_SIZE = `TLB_ENTRY_SIZE;
    localparam int VPN_W          = 27;
    localparam int PTE_W          = 64;
    localparam int TMO_W          = 8;   // walk timeout counter width (limit 1..255)
    localparam int CNT_W          = 16;  // completed-refill counter width

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_SEL,
        ST_WRITE
    } itlb_refill_state_e;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// Bundle of the refill controller's miss, page-walk, PLRU and entry-write
// signals. "master" is the controller's view; "slave" is the surrounding
// ITLB / walker / PLRU view.
interface itlb_refill_ctrl_if #(
    parameter int ENTRY_N = `TLB_ENTRY_SIZE,
    parameter int VPN_W   = mms_pkg::VPN_W,
    parameter int PTE_W   = mms_pkg::PTE_W
);
    logic               miss_vld;
    logic [VPN_W-1:0]   miss_vpn;
    logic               miss_rdy;
    logic               flush;
    logic               ptw_req_vld;
    logic               ptw_req_rdy;
    logic [VPN_W-1:0]   ptw_req_vpn;
    logic               ptw_resp_vld;
    logic               ptw_resp_err;
    logic [PTE_W-1:0]   ptw_resp_pte;
    logic               refill_init_en;
    logic [ENTRY_N-1:0] refill_onehot;
    logic               refill_vld;
    logic               entry_wr_en;
    logic [ENTRY_N-1:0] entry_wr_onehot;
    logic [VPN_W-1:0]   entry_wr_vpn;
    logic [PTE_W-1:0]   entry_wr_pte;
    logic               fault;
    logic               busy;
    logic [15:0]        refill_cnt;

    modport master (
        input  miss_vld, miss_vpn, flush, ptw_req_rdy, ptw_resp_vld,
               ptw_resp_err, ptw_resp_pte, refill_onehot,
        output miss_rdy, ptw_req_vld, ptw_req_vpn, refill_init_en, refill_vld,
               entry_wr_en, entry_wr_onehot, entry_wr_vpn, entry_wr_pte,
               fault, busy, refill_cnt
    );

    modport slave (
        output miss_vld, miss_vpn, flush, ptw_req_rdy, ptw_resp_vld,
               ptw_resp_err, ptw_resp_pte, refill_onehot,
        input  miss_rdy, ptw_req_vld, ptw_req_vpn, refill_init_en, refill_vld,
               entry_wr_en, entry_wr_onehot, entry_wr_vpn, entry_wr_pte,
               fault, busy, refill_cnt
    );

endinterface

// File: rtl/itlb_refill_ctrl.sv
// ITLB miss refill controller: accepts one miss at a time, issues a page
// walk, waits for the PTE (with timeout), lets the PLRU pick a victim, then
// writes the entry. Flush aborts the refill without fault or write; a walk
// already issued is still drained so the walker never sees a dropped response.
module itlb_refill_ctrl #(
    parameter int ENTRY_N  = `TLB_ENTRY_SIZE,
    parameter int VPN_W    = mms_pkg::VPN_W,
    parameter int PTE_W    = mms_pkg::PTE_W,
    parameter int WALK_TMO = 255
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               miss_vld_i,
    input  logic [VPN_W-1:0]   miss_vpn_i,
    output logic               miss_rdy_o,
    input  logic               flush_i,
    output logic               ptw_req_vld_o,
    input  logic               ptw_req_rdy_i,
    output logic [VPN_W-1:0]   ptw_req_vpn_o,
    input  logic               ptw_resp_vld_i,
    input  logic               ptw_resp_err_i,
    input  logic [PTE_W-1:0]   ptw_resp_pte_i,
    output logic               refill_init_en_o,
    input  logic [ENTRY_N-1:0] refill_onehot_i,
    output logic               refill_vld_o,
    output logic               entry_wr_en_o,
    output logic [ENTRY_N-1:0] entry_wr_onehot_o,
    output logic [VPN_W-1:0]   entry_wr_vpn_o,
    output logic [PTE_W-1:0]   entry_wr_pte_o,
    output logic               fault_o,
    output logic               busy_o,
    output logic [15:0]        refill_cnt_o
);
    import mms_pkg::itlb_refill_state_e, mms_pkg::ST_IDLE, mms_pkg::ST_REQ,
           mms_pkg::ST_WAIT, mms_pkg::ST_SEL, mms_pkg::ST_WRITE,
           mms_pkg::TMO_W, mms_pkg::CNT_W, mms_pkg::sat_inc;

    localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(WALK_TMO);

    itlb_refill_state_e state_q, state_d;
    logic               kill_q, kill_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
    logic [VPN_W-1:0]   vpn_q, vpn_d;
    logic [PTE_W-1:0]   pte_q, pte_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   refill_cnt_q, refill_cnt_d;
    logic               wr_fire;

    // Next-state and datapath capture; fault is a registered one-cycle pulse.
    always_comb begin
        state_d      = state_q;
        kill_d       = kill_q;
        tmo_d        = tmo_q;
        vpn_d        = vpn_q;
        pte_d        = pte_q;
        fault_d      = 1'b0;
        refill_cnt_d = refill_cnt_q;
        tmo_inc      = tmo_q + 1'b1;
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (miss_vld_i && !flush_i) begin
                    vpn_d   = miss_vpn_i;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A flushed request still finishes its handshake.
                if (flush_i) kill_d = 1'b1;
                if (ptw_req_rdy_i) begin
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                tmo_d = tmo_inc;
                if (ptw_resp_vld_i) begin
                    state_d = ST_IDLE;
                    if (!(kill_q || flush_i)) begin
                        if (ptw_resp_err_i) begin
                            fault_d = 1'b1;
                        end else begin
                            pte_d   = ptw_resp_pte_i;
                            state_d = ST_SEL;
                        end
                    end
                end else if (tmo_inc == TMO_LIM) begin
                    state_d = ST_IDLE;
                    fault_d = !(kill_q || flush_i);
                end else if (flush_i) begin
                    kill_d = 1'b1;
                end
            end
            // One bubble so the PLRU can register its victim index.
            ST_SEL: state_d = flush_i ? ST_IDLE : ST_WRITE;
            ST_WRITE: begin
                state_d = ST_IDLE;
                if (!flush_i) refill_cnt_d = sat_inc(refill_cnt_q);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and capture registers; reset aborts any refill in flight.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            kill_q       <= 1'b0;
            tmo_q        <= '0;
            vpn_q        <= '0;
            pte_q        <= '0;
            fault_q      <= 1'b0;
            refill_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            kill_q       <= kill_d;
            tmo_q        <= tmo_d;
            vpn_q        <= vpn_d;
            pte_q        <= pte_d;
            fault_q      <= fault_d;
            refill_cnt_q <= refill_cnt_d;
        end
    end

    // Outputs are gated by state so every strobe/bus is zero outside its owner.
    always_comb begin
        wr_fire           = (state_q == ST_WRITE) && !flush_i;
        miss_rdy_o        = (state_q == ST_IDLE) && !flush_i;
        ptw_req_vld_o     = (state_q == ST_REQ);
        ptw_req_vpn_o     = (state_q == ST_REQ) ? vpn_q : '0;
        refill_init_en_o  = (state_q == ST_SEL);
        refill_vld_o      = wr_fire;
        entry_wr_en_o     = wr_fire;
        entry_wr_onehot_o = wr_fire ? refill_onehot_i : '0;
        entry_wr_vpn_o    = wr_fire ? vpn_q : '0;
        entry_wr_pte_o    = wr_fire ? pte_q : '0;
        fault_o           = fault_q;
        busy_o            = (state_q != ST_IDLE);
        refill_cnt_o      = refill_cnt_q;
    end

endmodule

// File: doc/itlb_refill_ctrl.md
ITLB_REFILL_CTRL -- requirements
Module: itlb_refill_ctrl

Interface
REQ-001 SHALL have parameter ENTRY_N, default `TLB_ENTRY_SIZE (32), meaning ITLB entry count and onehot width.
REQ-002 SHALL have parameter VPN_W, default 27, meaning virtual page number width.
REQ-003 SHALL have parameter PTE_W, default 64, meaning page-table entry width.
REQ-004 SHALL have parameter WALK_TMO, default 255, meaning the maximum WAIT cycles before timeout (1..255).
REQ-005 SHALL use one clock and an asynchronous active-low reset, with these ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- miss_vld_i  in  1  ITLB lookup miss
- miss_vpn_i  in  VPN_W  missing VPN
- miss_rdy_o  out  1  miss accepted this cycle
- flush_i  in  1  sfence/flush abort
- ptw_req_vld_o  out  1  page-walk request
- ptw_req_rdy_i  in  1  page-walk request accepted
- ptw_req_vpn_o  out  VPN_W  VPN to walk
- ptw_resp_vld_i  in  1  walk response valid
- ptw_resp_err_i  in  1  walk fault
- ptw_resp_pte_i  in  PTE_W  returned PTE
- refill_init_en_o  out  1  latch replacement index in the PLRU unit
- refill_onehot_i  in  ENTRY_N  victim onehot from the PLRU unit
- refill_vld_o  out  1  PLRU write-update strobe
- entry_wr_en_o  out  1  ITLB entry write
- entry_wr_onehot_o  out  ENTRY_N  entry select
- entry_wr_vpn_o  out  VPN_W  tag to write
- entry_wr_pte_o  out  PTE_W  PTE to write
- fault_o  out  1  one-cycle fault pulse
- busy_o  out  1  state != IDLE
- refill_cnt_o  out  16  completed refills, saturating

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT, SEL, WRITE, plus a kill flag.
REQ-007 IDLE: miss_rdy_o = !flush_i; on miss_vld_i && miss_rdy_o, capture miss_vpn_i and go to REQ.
REQ-008 REQ: ptw_req_vld_o = 1 with the captured VPN, held stable until ptw_req_rdy_i; on handshake go to WAIT and clear the timeout counter.
REQ-009 WAIT: the counter increments each cycle.
- ptw_resp_vld_i with err: fault_o pulses next cycle, go to IDLE.
- ptw_resp_vld_i without err: capture the PTE, pulse refill_init_en_o for one cycle, go to SEL.
- Counter reaching WALK_TMO without a response: fault_o pulses, go to IDLE; a later stray response is ignored.
REQ-010 SEL: exactly one bubble cycle for the PLRU index register; go to WRITE.
REQ-011 WRITE: for one cycle assert entry_wr_en_o and refill_vld_o, with entry_wr_onehot_o = refill_onehot_i and the captured VPN/PTE; increment refill_cnt_o (saturates at 16'hFFFF); go to IDLE.
REQ-012 The miss-to-write latency SHALL be 1 (REQ) + request stall + response latency + 2 cycles (SEL, WRITE).
REQ-013 flush_i in REQ SHALL set kill, and the request SHALL still complete its handshake.
REQ-014 flush_i in WAIT, or kill already set, SHALL wait for the response or timeout, then discard it with no fault and no write, and return to IDLE.
REQ-015 flush_i in SEL or WRITE SHALL send the FSM to IDLE, suppress entry_wr_en_o and refill_vld_o, and leave refill_cnt_o unchanged.
REQ-016 flush_i in IDLE SHALL only block acceptance that cycle.
REQ-017 Simultaneous flush_i and ptw_resp_vld_i in WAIT SHALL discard the response.
REQ-018 Exactly one refill SHALL be outstanding at a time; miss_rdy_o = 0 outside IDLE.
REQ-019 All write/strobe outputs SHALL be zero whenever the FSM is not in the state that drives them.

Reset
REQ-020 On rstn_i low the FSM SHALL enter IDLE immediately, even mid-refill, with no write or fault emitted.
REQ-021 On rstn_i low the kill flag, timeout counter, captured VPN/PTE and refill_cnt_o SHALL be 0.
REQ-022 Reset values SHALL be:
- all *_vld_o, *_en_o, fault_o, busy_o: 0
- entry_wr_onehot_o: 0
- miss_rdy_o: 1 (unless flush_i)

Structure
REQ-023 The state enum typedef itlb_refill_state_e, VPN_W and PTE_W SHALL live in mms_pkg, next to `TLB_ENTRY_SIZE.
REQ-024 SHALL have no sub-module; the PLRU replacement unit is instantiated by the parent ITLB, connected via refill_init_en_o, refill_onehot_i and refill_vld_o.

Verification
REQ-025 Normal refill: miss vpn=0x1234, rdy immediate, response 3 cycles later with pte=0xABCD -> one entry_wr_en_o pulse with onehot = refill_onehot_i, vpn 0x1234, pte 0xABCD; refill_cnt_o = 1.
REQ-026 Request backpressure: ptw_req_rdy_i low for 5 cycles -> ptw_req_vld_o and VPN stable for 6 cycles, exactly one handshake.
REQ-027 Fault and timeout:
- ptw_resp_err_i = 1 -> fault_o single pulse, no write.
- WALK_TMO = 4 with no response -> fault_o after 4 WAIT cycles, next miss accepted.
REQ-028 Flush in each of REQ/WAIT/SEL/WRITE -> no entry_wr_en_o, no refill_vld_o, refill_cnt_o unchanged, back to IDLE.
REQ-029 rstn_i asserted during WAIT -> all outputs at reset values the same cycle; a response arriving after reset release causes no write.
REQ-030 Saturation: preload 0xFFFE, run 3 refills -> refill_cnt_o = 0xFFFF.
